// File: rtl/mul_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state
// encodings, operand-signedness encodings and iteration counts.
package mul_seq_pkg;

  typedef enum logic [2:0] {
    MUL_IDLE   = 3'd0,
    MUL_ABS_A  = 3'd1,
    MUL_ABS_B  = 3'd2,
    MUL_CALC   = 3'd3,
    MUL_NEG_LO = 3'd4,
    MUL_NEG_HI = 3'd5,
    MUL_DONE   = 3'd6
  } mul_state_e;

  // op_sign encodings: [1] multiplicand signed, [0] multiplier signed.
  localparam logic [1:0] MUL_SIGN_UU = 2'b00;  // MULHU
  localparam logic [1:0] MUL_SIGN_SS = 2'b11;  // MULH
  localparam logic [1:0] MUL_SIGN_SU = 2'b10;  // MULHSU

  // Number of shift-add iterations for full-width and word operations.
  localparam int MUL_ITER_64 = 64;
  localparam int MUL_ITER_32 = 32;

  // Sign-extend a 32-bit word result to 64 bits.
  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

endpackage

// File: rtl/mul_seq_add.sv
// Team 64-bit ripple-carry adder. With alu_32 set the sum is reduced to
// its low word and sign-extended; the carry out always comes from bit 63.
module ysyx_2022040010_add (
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_c,
  input  logic        alu_32,
  output logic [63:0] out_s,
  output logic        out_c
);

  logic [63:0] prop;
  logic [63:0] gen;
  logic [63:0] sum;

  // Per-bit propagate/generate terms.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_pg
      assign prop[gi] = in_a[gi] ^ in_b[gi];
      assign gen[gi]  = in_a[gi] & in_b[gi];
    end
  endgenerate

  // Ripple the carry from bit 0 upwards.
  always_comb begin
    logic c;
    c   = in_c;
    sum = '0;
    for (int i = 0; i < 64; i++) begin
      sum[i] = prop[i] ^ c;
      c      = gen[i] | (prop[i] & c);
    end
    out_c = c;
  end

  // Optional word-mode result.
  always_comb begin
    out_s = alu_32 ? {{32{sum[31]}}, sum[31:0]} : sum;
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier. Signed high-half products are
// computed on magnitudes (ABS_A/ABS_B) and the 128-bit product is negated
// afterwards (NEG_LO/NEG_HI). One shared ripple adder does all arithmetic.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_w,
  input  logic            op_hi,
  input  logic [1:0]      op_sign,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mul_state_e       state_reg;
  logic [XLEN-1:0]  a_reg;
  logic [XLEN-1:0]  hi_reg;
  logic [XLEN-1:0]  lo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_reg;
  logic             abs_reg;
  logic             carry_reg;
  logic             op_w_reg;
  logic             op_hi_reg;
  logic [1:0]       op_sign_reg;
  logic             out_valid_reg;
  logic [XLEN-1:0]  result_reg;

  logic [XLEN-1:0]  add_a;
  logic [XLEN-1:0]  add_b;
  logic             add_c;
  logic [XLEN-1:0]  add_s;
  logic             add_co;
  logic             take_abs;
  logic [XLEN-1:0]  sel_result;

  assign in_ready  = (state_reg == MUL_IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

  // Only signed high-half full-width products need the magnitude path;
  // low halves are identical for any signedness.
  assign take_abs = op_hi & ~op_w & (op_sign != MUL_SIGN_UU);

  // Word results live in lo[63:32] after 32 iterations.
  assign sel_result = op_w_reg  ? sext32(lo_reg[63:32]) :
                      op_hi_reg ? hi_reg : lo_reg;

  // Adder operand steering; held at zero when idle or done.
  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    case (state_reg)
      MUL_ABS_A: begin
        add_a = ~a_reg;
        add_c = 1'b1;
      end
      MUL_ABS_B: begin
        add_a = ~lo_reg;
        add_c = 1'b1;
      end
      MUL_CALC: begin
        add_a = hi_reg;
        add_b = lo_reg[0] ? a_reg : '0;
      end
      MUL_NEG_LO: begin
        add_a = ~lo_reg;
        add_c = 1'b1;
      end
      MUL_NEG_HI: begin
        add_a = ~hi_reg;
        add_c = carry_reg;
      end
      default: ;
    endcase
  end

  ysyx_2022040010_add u_add (
    .in_a   (add_a),
    .in_b   (add_b),
    .in_c   (add_c),
    .alu_32 (1'b0),
    .out_s  (add_s),
    .out_c  (add_co)
  );

  // Sequencer FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MUL_IDLE;
      a_reg         <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      cnt_reg       <= '0;
      neg_reg       <= 1'b0;
      abs_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      op_w_reg      <= 1'b0;
      op_hi_reg     <= 1'b0;
      op_sign_reg   <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
    end else if (flush) begin
      // Abort; the stale result register is left as is.
      state_reg     <= MUL_IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        MUL_IDLE: begin
          if (in_valid) begin
            op_w_reg    <= op_w;
            op_hi_reg   <= op_hi;
            op_sign_reg <= op_sign;
            neg_reg     <= (src_a[XLEN-1] & op_sign[1]) ^ (src_b[XLEN-1] & op_sign[0]);
            abs_reg     <= take_abs;
            hi_reg      <= '0;
            if (op_w) begin
              a_reg   <= {32'b0, src_a[31:0]};
              lo_reg  <= {32'b0, src_b[31:0]};
              cnt_reg <= CNT_W'(MUL_ITER_32);
            end else begin
              a_reg   <= src_a;
              lo_reg  <= src_b;
              cnt_reg <= CNT_W'(MUL_ITER_64);
            end
            state_reg <= take_abs ? MUL_ABS_A : MUL_CALC;
          end
        end
        MUL_ABS_A: begin
          if (a_reg[XLEN-1] & op_sign_reg[1]) a_reg <= add_s;
          state_reg <= MUL_ABS_B;
        end
        MUL_ABS_B: begin
          if (lo_reg[XLEN-1] & op_sign_reg[0]) lo_reg <= add_s;
          state_reg <= MUL_CALC;
        end
        MUL_CALC: begin
          hi_reg  <= {add_co, add_s[XLEN-1:1]};
          lo_reg  <= {add_s[0], lo_reg[XLEN-1:1]};
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= abs_reg ? MUL_NEG_LO : MUL_DONE;
        end
        MUL_NEG_LO: begin
          if (neg_reg) begin
            lo_reg    <= add_s;
            carry_reg <= add_co;
          end
          state_reg <= MUL_NEG_HI;
        end
        MUL_NEG_HI: begin
          if (neg_reg) hi_reg <= add_s;
          state_reg <= MUL_DONE;
        end
        MUL_DONE: begin
          // First cycle captures the result; it is then held until taken.
          if (!out_valid_reg) begin
            result_reg    <= sel_result;
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= MUL_IDLE;
          end
        end
        default: state_reg <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and small randomized checks of the sequential multiplier:
// results, latencies, backpressure, flush and reset.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_w = 1'b0;
  logic        op_hi = 1'b0;
  logic [1:0]  op_sign = 2'b00;
  logic [63:0] src_a = '0;
  logic [63:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_w      (op_w),
    .op_hi     (op_hi),
    .op_sign   (op_sign),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 128-bit product of sign/zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic w, input logic hi, input logic [1:0] sg,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0]  pw;
    if (w) begin
      pw = {32'b0, a[31:0]} * {32'b0, b[31:0]};
      return {{32{pw[31]}}, pw[31:0]};
    end
    ea = sg[1] ? {{64{a[63]}}, a} : {64'b0, a};
    eb = sg[0] ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return hi ? p[127:64] : p[63:0];
  endfunction

  // Issue one operation from a negedge, wait for the result, optionally
  // stall the consumer, then retire it. Ends on a negedge.
  task automatic do_op(input string tag, input logic w, input logic hi, input logic [1:0] sg,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat, input int hold);
    int          lat;
    logic        busy_bad;
    logic        stall_bad;
    logic [63:0] held;
    busy_bad  = 1'b0;
    stall_bad = 1'b0;
    op_w = w; op_hi = hi; op_sign = sg; src_a = a; src_b = b; in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src_a = ~a;
    src_b = ~b;
    op_sign = ~sg;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) busy_bad = 1'b1;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " busy"}, 64'(busy_bad), 64'd0);
    held = result;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) stall_bad = 1'b1;
      end
      check({tag, " stall"}, 64'(stall_bad), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " retire out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " retire in_ready"}, 64'(in_ready), 64'd1);
    $display("op %s w=%0b hi=%0b sg=%b a=%h b=%h -> %h lat=%0d", tag, w, hi, sg, a, b, held, lat);
  endtask

  initial begin
    logic [63:0] ra, rb, rexp;
    logic [1:0]  rsg;
    logic        rw, rhi;
    int          k, rlat;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    do_op("mulhu", 1'b0, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 65, 0);
    do_op("mul_bp", 1'b0, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 10);
    do_op("mulh_neg", 1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 69, 0);
    do_op("mulh_pos", 1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 69, 0);
    do_op("mulhsu", 1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 69, 0);
    do_op("mulw", 1'b1, 1'b0, 2'b00, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    do_op("mul_slo", 1'b0, 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    do_op("mulh_min", 1'b0, 1'b1, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 69, 0);

    // Flush during CALC, then an immediate new request.
    op_w = 1'b0; op_hi = 1'b0; op_sign = 2'b00; src_a = 64'd5; src_b = 64'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush out_valid", 64'(out_valid), 64'd0);
    do_op("after_flush", 1'b0, 1'b0, 2'b00, 64'd123456789, 64'd1000, 64'd123456789000, 65, 0);

    // A request presented together with flush is dropped.
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_req in_ready", 64'(in_ready), 64'd1);

    // Reset mid-CALC together with a request.
    op_w = 1'b0; op_hi = 1'b1; op_sign = 2'b00; src_a = 64'd9; src_b = 64'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", result, 64'd0);
    do_op("after_rst", 1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 69, 0);

    // Short randomized regression against a 128-bit reference.
    for (int n = 0; n < 30; n++) begin
      k  = $urandom_range(0, 4);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 7 == 3) ra = 64'h8000_0000_0000_0000;
      if (n % 5 == 2) rb = 64'hFFFF_FFFF_FFFF_FFFF;
      rw = 1'b0; rhi = 1'b1; rsg = 2'b00;
      case (k)
        0: begin
          rhi = 1'b0;
          rsg = (n % 3 == 0) ? 2'b00 : ((n % 3 == 1) ? 2'b11 : 2'b10);
        end
        1: rsg = 2'b11;
        2: rsg = 2'b10;
        3: rsg = 2'b00;
        default: begin
          rw = 1'b1;
          rhi = n[0];
          rsg = 2'b11;
        end
      endcase
      rexp = ref_mul(rw, rhi, rsg, ra, rb);
      rlat = rw ? 33 : ((rhi && rsg != 2'b00) ? 69 : 65);
      do_op("rand", rw, rhi, rsg, ra, rb, rexp, rlat, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative radix-2 shift-add multiplier sequencer for the EXU.
- It time-shares one instance of the team's 64-bit ripple adder (ysyx_2022040010_add), one add per cycle, to produce the RISC-V M-extension multiply results MUL, MULH, MULHSU, MULHU and MULW.
- It sits beside the ALU and is driven by the EXU stall logic through a valid/ready handshake on both input and output.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, width of the iteration counter; must hold XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; aborts any operation in flight.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; equals (state==IDLE).
- op_w  in  1  MULW: 32-bit operands, 32-bit result sign-extended.
- op_hi  in  1  return the high 64 bits of the product instead of the low 64.
- op_sign  in  2  [1]=multiplicand signed, [0]=multiplier signed; legal values 00, 11, 10.
- src_a  in  64  multiplicand.
- src_b  in  64  multiplier.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- result  out  64  selected result.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, internal hi/lo/cnt/neg registers=0.
- States: IDLE, ABS_A, ABS_B, CALC, NEG_LO, NEG_HI, DONE.
- Accept: in_valid & in_ready at edge T latches the operands and the op fields, and sets neg = sign(a)&op_sign[1] ^ sign(b)&op_sign[0].
  - Next state is ABS_A if (op_hi & op_sign!=00); otherwise CALC.
  - op_sign is ignored when op_hi=0 or op_w=1, because the low bits of a product are sign-agnostic.
- ABS_A: if a is negative and signed, A <= ~A + 1 through the adder (in_c=1). Always lasts 1 cycle, then ABS_B.
- ABS_B: same operation for B, then CALC.
- CALC setup:
  - hi=0, lo=B (MULW: lo={32'b0,B[31:0]}, A={32'b0,A[31:0]}).
  - cnt=64, or 32 for MULW.
- CALC, per cycle:
  - Adder inputs are in_a=hi, in_b=(lo[0]?A:0), in_c=0, alu_32=0.
  - Update {hi,lo} <= {out_c, out_s, lo[63:1]}, then cnt--.
  - On the cycle cnt reaches 0, the next state is NEG_LO if the ABS path was taken; otherwise DONE.
- NEG_LO: if neg, lo <= ~lo + 1 and save the carry out; otherwise pass. 1 cycle.
- NEG_HI: if neg, hi <= ~hi + saved carry; otherwise pass. 1 cycle, then DONE.
- DONE: out_valid=1 and result is held stable.
  - Non-MULW: result = op_hi ? hi : lo.
  - MULW: result = sext(lo[63:32]).
  - When out_ready is high, the next state is IDLE and out_valid drops.
  - There is no input accept in the same cycle; in_ready is 0 while in DONE.
- Latency from the accept edge to out_valid:
  - 65 cycles for 64-bit unsigned or low-half operations.
  - 33 cycles for MULW.
  - 69 cycles for signed MULH/MULHSU.
- The adder is used only in ABS_*, CALC and NEG_*. Its inputs are driven to 0 in IDLE/DONE so they do not toggle.
- flush:
  - Any state goes to IDLE on the next edge and out_valid=0. The result register is not cleared; the pending result is discarded.
  - flush takes priority over in_valid and out_ready in the same cycle. A request presented with flush=1 is not accepted.
- rst mid-operation behaves like flush and additionally clears every register to its reset value.
- Inputs are sampled only at the accept edge. src_a/src_b may change during the operation without effect.
- op_sign=01 is illegal. Behaviour for it is undefined but the block must still terminate.

Decomposition:
- Shared defines (the defines.v include): state encodings MUL_IDLE..MUL_DONE, the op_sign encodings, and the iteration counts 64/32.
- One sub-module: ysyx_2022040010_add, instantiated once and unmodified.
- Operand muxing, the counter and the FSM stay in this module.

Test Plan:
- MULHU: src_a=0xFFFF_FFFF_FFFF_FFFF, src_b=2 -> after 65 cycles out_valid=1, result=0x1. The same operands with op_hi=0 give 0xFFFF_FFFF_FFFF_FFFE.
- MULH signed: src_a=-3, src_b=7, op_sign=11, op_hi=1 -> out_valid at 69 cycles, result=0xFFFF_FFFF_FFFF_FFFF. MULH with -3 * -7 gives 0.
- MULHSU: src_a=-1, src_b=0xFFFF_FFFF_FFFF_FFFF, op_sign=10 -> result=0xFFFF_FFFF_FFFF_FFFF.
- MULW: src_a=0x0000_0000_7FFF_FFFF, src_b=2 -> out_valid at 33 cycles, result=0xFFFF_FFFF_FFFF_FFFE. in_ready stays 0 throughout.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles: result and out_valid stay stable, and in_ready=0.
  - Separately, assert flush at CALC cycle 20: the block is in IDLE next cycle, out_valid never rises, and a new request the cycle after is accepted and completes correctly.
- Reset: assert rst in CALC together with in_valid=1 -> next cycle all outputs are at reset values and in_ready=1. Random regression of 10k ops is checked against a reference 128-bit multiply for all op types.
